// File: rtl/mult_ctrl_seq.sv
// mult_ctrl_seq
//   State sequencer for the iterative mantissa multiplier. Holds the 3-bit
//   control state that feeds the output_signal decoder, plus the iteration
//   counter, and runs the start/ack handshake with the FP top level, with
//   stall hold and synchronous abort.
//
// Ports
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   start      : request a multiply (sampled only in IDLE)
//   stall      : datapath not ready for next step (sampled only in ITER/HOLD)
//   abort      : synchronous cancel, any state -> IDLE
//   ack        : consumer has taken the result (sampled only in DONE)
//   q          : control state code to the decoder
//   iter_count : completed ITER steps in the current operation
//   last_iter  : current cycle is the final ITER step
//   busy       : q is LOAD, ITER or HOLD
//   state_err  : sticky flag, an illegal q code was seen
module mult_ctrl_seq #(
  parameter int N_BITS = 24,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  input  logic             ack,
  output logic [2:0]       q,
  output logic [CNT_W-1:0] iter_count,
  output logic             last_iter,
  output logic             busy,
  output logic             state_err
);

  // Codes are shared with the output_signal decoder and must not change.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    ITER = 3'b010,
    DONE = 3'b011,
    HOLD = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

  // Kept as a plain 3-bit vector so that the illegal codes 101/110/111 are
  // representable and recoverable.
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             on_last;

  assign on_last = (state_q == ITER) && (count_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;

    // An illegal code is flagged even when abort wins the transition.
    if (state_q inside {3'b101, 3'b110, 3'b111}) begin
      err_d = 1'b1;
    end

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_d = '0;
          if (start) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          state_d = ITER;
          count_d = '0;
        end
        ITER: begin
          if (on_last) begin
            // Final step: counter saturates at N_BITS-1 so it never wraps,
            // and stall no longer matters because the datapath is finished.
            state_d = DONE;
          end else begin
            count_d = count_q + CNT_W'(1);
            if (stall) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state_d = ITER;
          end
        end
        DONE: begin
          if (ack) begin
            state_d = IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign q          = state_q;
  assign iter_count = count_q;
  assign last_iter  = on_last;
  assign busy       = (state_q == LOAD) || (state_q == ITER) || (state_q == HOLD);
  assign state_err  = err_q;

endmodule

// File: tb/tb_mult_ctrl_seq.sv
// tb_mult_ctrl_seq
//   Directed bench for mult_ctrl_seq with N_BITS=4: nominal run, stall/HOLD,
//   stall on last step, DONE handshake, abort in ITER and HOLD, async reset
//   mid-operation and illegal-state recovery with sticky state_err.
module tb_mult_ctrl_seq;

  localparam int NB = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stall, abort, ack;
  logic [2:0]    q;
  logic [CW-1:0] iter_count;
  logic          last_iter, busy, state_err;

  int vectors = 0;
  int miscompares = 0;

  mult_ctrl_seq #(.N_BITS(NB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stall      (stall),
    .abort      (abort),
    .ack        (ack),
    .q          (q),
    .iter_count (iter_count),
    .last_iter  (last_iter),
    .busy       (busy),
    .state_err  (state_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check every output at once against expected q/count/last/busy/err.
  task automatic chk_all(input string tag, input logic [2:0] eq, input int ec,
                         input logic el, input logic eb, input logic ee);
    chk({tag, ".q"},     32'(q), 32'(eq));
    chk({tag, ".cnt"},   32'(iter_count), 32'(ec));
    chk({tag, ".last"},  32'(last_iter), 32'(el));
    chk({tag, ".busy"},  32'(busy), 32'(eb));
    chk({tag, ".err"},   32'(state_err), 32'(ee));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; stall = 1'b0; abort = 1'b0; ack = 1'b0;
    #12;
    chk_all("reset", 3'b000, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Nominal operation.
    start = 1'b1; step(); start = 1'b0;
    chk_all("nom_load", 3'b001, 0, 0, 1, 0);
    step(); chk_all("nom_it0", 3'b010, 0, 0, 1, 0);
    step(); chk_all("nom_it1", 3'b010, 1, 0, 1, 0);
    step(); chk_all("nom_it2", 3'b010, 2, 0, 1, 0);
    step(); chk_all("nom_it3", 3'b010, 3, 1, 1, 0);
    step(); chk_all("nom_done", 3'b011, 3, 0, 0, 0);
    ack = 1'b1; step(); ack = 1'b0;
    chk_all("nom_idle", 3'b000, 0, 0, 0, 0);

    // Stall during 2nd ITER cycle for 3 cycles.
    start = 1'b1; step(); start = 1'b0;
    chk_all("st_load", 3'b001, 0, 0, 1, 0);
    step(); chk_all("st_it0", 3'b010, 0, 0, 1, 0);
    step(); chk_all("st_it1", 3'b010, 1, 0, 1, 0);
    stall = 1'b1;
    step(); chk_all("st_h0", 3'b100, 2, 0, 1, 0);
    step(); chk_all("st_h1", 3'b100, 2, 0, 1, 0);
    step(); chk_all("st_h2", 3'b100, 2, 0, 1, 0);
    stall = 1'b0;
    step(); chk_all("st_it2", 3'b010, 2, 0, 1, 0);
    step(); chk_all("st_it3", 3'b010, 3, 1, 1, 0);
    step(); chk_all("st_done", 3'b011, 3, 0, 0, 0);

    // DONE waits for ack; start alone is ignored.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      step(); chk("done_wait.q", 32'(q), 32'h3);
    end
    start = 1'b1; ack = 1'b1; step(); ack = 1'b0;
    chk_all("ack_start", 3'b000, 0, 0, 0, 0);
    step(); start = 1'b0;
    chk_all("restart", 3'b001, 0, 0, 1, 0);

    // Stall on the last step goes straight to DONE.
    step(); chk("ls_it0.q", 32'(q), 32'h2);
    step(); chk("ls_it1.cnt", 32'(iter_count), 32'h1);
    step(); chk("ls_it2.cnt", 32'(iter_count), 32'h2);
    step(); chk_all("ls_it3", 3'b010, 3, 1, 1, 0);
    stall = 1'b1;
    step(); stall = 1'b0;
    chk_all("ls_done", 3'b011, 3, 0, 0, 0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ls_idle.q", 32'(q), 32'h0);

    // Abort in ITER at iter_count=2.
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk_all("ab_it2", 3'b010, 2, 0, 1, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk_all("ab_iter", 3'b000, 0, 0, 0, 0);

    // Abort in HOLD.
    start = 1'b1; step(); start = 1'b0;
    step(); chk("abh_it0.q", 32'(q), 32'h2);
    stall = 1'b1; step();
    chk_all("abh_hold", 3'b100, 1, 0, 1, 0);
    abort = 1'b1; step(); abort = 1'b0; stall = 1'b0;
    chk_all("ab_hold", 3'b000, 0, 0, 0, 0);

    // Full operation after aborts.
    start = 1'b1; step(); start = 1'b0;
    chk("pa_load.q", 32'(q), 32'h1);
    for (int i = 0; i < NB; i++) begin
      step();
      chk("pa_iter.q", 32'(q), 32'h2);
      chk("pa_iter.cnt", 32'(iter_count), 32'(i));
    end
    step(); chk("pa_done.q", 32'(q), 32'h3);
    abort = 1'b1; step(); abort = 1'b0;
    chk_all("ab_done", 3'b000, 0, 0, 0, 0);

    // Async reset mid-ITER, released off-edge.
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk_all("ar_it1", 3'b010, 1, 0, 1, 0);
    #2 reset_n = 1'b0;
    #1 chk_all("ar_async", 3'b000, 0, 0, 0, 0);
    #3 reset_n = 1'b1;
    step(); chk_all("ar_after", 3'b000, 0, 0, 0, 0);

    // Illegal state code recovery.
    @(negedge clk);
    force dut.state_q = 3'b110;
    #1 release dut.state_q;
    #1 chk("ill_forced.q", 32'(q), 32'h6);
    chk("ill_forced.busy", 32'(busy), 32'h0);
    step(); chk_all("ill_rec", 3'b000, 0, 0, 0, 1);
    start = 1'b1; step(); start = 1'b0;
    chk_all("ill_sticky", 3'b001, 0, 0, 1, 1);
    step(); step();
    chk("ill_sticky2.err", 32'(state_err), 32'h1);
    #2 reset_n = 1'b0;
    #1 chk_all("ill_reset", 3'b000, 0, 0, 0, 0);
    #3 reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
